// File: rtl/partial_reduce_pipe_if.sv
// Handshake bundle for partial_reduce_pipe: operand input side, flush,
// and the FIFO head / occupancy output side.
interface partial_reduce_pipe_if #(
  parameter int WIDTH = 2,
  parameter int NCH   = 2,
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NCH*(WIDTH-1)-1:0] I;
  logic [NCH-1:0]           lifted_input;
  logic                     in_valid;
  logic                     in_ready;
  logic                     flush;
  logic [WIDTH-1:0]         O;
  logic [WIDTH-1:0]         O_n;
  logic                     lifted_output;
  logic                     out_valid;
  logic                     out_ready;
  logic [CNT_W-1:0]         count;

  // Environment side: offers operands, consumes results.
  modport master (
    output I, lifted_input, in_valid, flush, out_ready,
    input  in_ready, O, O_n, lifted_output, out_valid, count
  );

  // Block side.
  modport slave (
    input  I, lifted_input, in_valid, flush, out_ready,
    output in_ready, O, O_n, lifted_output, out_valid, count
  );
endinterface

// File: rtl/partial_reduce_pipe.sv
// Bitwise OR/AND/XOR reduction across NCH operand channels, registered in a
// single stage (S1) and then buffered in a DEPTH-entry output FIFO.
module partial_reduce_pipe #(
  parameter int WIDTH = 2,
  parameter int NCH   = 2,
  parameter int DEPTH = 2,
  parameter int MODE  = 0
) (
  input logic                 CLK,
  input logic                 ASYNCRESETN,
  partial_reduce_pipe_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LOW_W = WIDTH - 1;

  typedef logic [WIDTH-1:0] word_t;

  // Each channel operand is its lifted MSB over its slice of low bits.
  function automatic word_t reduce_ops(input logic [NCH*LOW_W-1:0] low,
                                       input logic [NCH-1:0]       msb);
    word_t acc;
    word_t op;
    acc = {msb[0], low[0 +: LOW_W]};
    for (int c = 1; c < NCH; c++) begin
      op = {msb[c], low[c*LOW_W +: LOW_W]};
      case (MODE)
        1:       acc = acc & op;
        2:       acc = acc ^ op;
        default: acc = acc | op;
      endcase
    end
    return acc;
  endfunction

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  word_t            res_p0;
  word_t            res_p1;
  logic             vld_p1;
  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             rdy_en;
  logic             fifo_has_room;
  logic             pop;
  logic             push_fifo;
  logic             accept;
  word_t            head;

  // ---- stage p0: combinational reduction of the offered operand set ----
  assign res_p0 = reduce_ops(bus.I, bus.lifted_input);

  assign fifo_has_room = (count_q < CNT_W'(DEPTH));
  assign pop           = bus.out_valid && bus.out_ready && !bus.flush;
  assign push_fifo     = vld_p1 && (fifo_has_room || pop) && !bus.flush;
  assign bus.in_ready  = rdy_en
                       && (!vld_p1 || fifo_has_room || (bus.out_valid && bus.out_ready))
                       && !bus.flush;
  assign accept        = bus.in_valid && bus.in_ready;

  // Holds in_ready low during reset and for the first edge after release.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) rdy_en <= 1'b0;
    else              rdy_en <= 1'b1;
  end

  // ---- stage p1: S1 register, filled on handshake, drained into the FIFO ----
  // S1 captures a new result on handshake, or empties when it moves into the FIFO.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
    end else if (bus.flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
      res_p1 <= res_p0;
    end else if (push_fifo) begin
      vld_p1 <= 1'b0;
    end
  end

  // ---- stage p2: output FIFO ----
  // FIFO storage, pointers and occupancy; flush drops everything in flight.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_fifo) begin
        mem[wr_ptr] <= res_p1;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push_fifo, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Outputs come from the head entry only, never from the inputs.
  assign head              = mem[rd_ptr];
  assign bus.O             = head;
  assign bus.O_n           = ~head;
  assign bus.lifted_output = head[0];
  assign bus.out_valid     = (count_q != '0);
  assign bus.count         = count_q;

endmodule

// File: tb/tb_partial_reduce_pipe.sv
// Bench for partial_reduce_pipe: four instances (OR/D2, AND/D2, XOR/D2,
// XOR/D3) share one stimulus; OR/D2 and XOR/D3 are tracked by a queue model.
module tb_partial_reduce_pipe;
  logic       CLK;
  logic       rst_n;
  logic [1:0] stim_i;
  logic [1:0] stim_li;
  logic       stim_valid;
  logic       stim_flush;
  logic       stim_ready;

  partial_reduce_pipe_if #(.WIDTH(2), .NCH(2), .DEPTH(2)) bus0 ();
  partial_reduce_pipe_if #(.WIDTH(2), .NCH(2), .DEPTH(2)) bus1 ();
  partial_reduce_pipe_if #(.WIDTH(2), .NCH(2), .DEPTH(2)) bus2 ();
  partial_reduce_pipe_if #(.WIDTH(2), .NCH(2), .DEPTH(3)) bus3 ();

  assign bus0.I = stim_i;  assign bus0.lifted_input = stim_li;  assign bus0.in_valid = stim_valid;
  assign bus0.flush = stim_flush;  assign bus0.out_ready = stim_ready;
  assign bus1.I = stim_i;  assign bus1.lifted_input = stim_li;  assign bus1.in_valid = stim_valid;
  assign bus1.flush = stim_flush;  assign bus1.out_ready = stim_ready;
  assign bus2.I = stim_i;  assign bus2.lifted_input = stim_li;  assign bus2.in_valid = stim_valid;
  assign bus2.flush = stim_flush;  assign bus2.out_ready = stim_ready;
  assign bus3.I = stim_i;  assign bus3.lifted_input = stim_li;  assign bus3.in_valid = stim_valid;
  assign bus3.flush = stim_flush;  assign bus3.out_ready = stim_ready;

  partial_reduce_pipe #(.WIDTH(2), .NCH(2), .DEPTH(2), .MODE(0)) u0 (.CLK(CLK), .ASYNCRESETN(rst_n), .bus(bus0));
  partial_reduce_pipe #(.WIDTH(2), .NCH(2), .DEPTH(2), .MODE(1)) u1 (.CLK(CLK), .ASYNCRESETN(rst_n), .bus(bus1));
  partial_reduce_pipe #(.WIDTH(2), .NCH(2), .DEPTH(2), .MODE(2)) u2 (.CLK(CLK), .ASYNCRESETN(rst_n), .bus(bus2));
  partial_reduce_pipe #(.WIDTH(2), .NCH(2), .DEPTH(3), .MODE(2)) u3 (.CLK(CLK), .ASYNCRESETN(rst_n), .bus(bus3));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Model state: index 0 tracks u0 (OR, depth 2), index 1 tracks u3 (XOR, depth 3).
  logic [1:0] q0 [$];
  logic [1:0] q3 [$];
  logic       ms1v [2];
  logic [1:0] ms1d [2];
  logic       mrdy [2];
  logic       erdy [2];
  logic       last_acc [2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_red(input int mode, input logic [1:0] i, input logic [1:0] li);
    logic [1:0] a;
    logic [1:0] b;
    a = {li[0], i[0]};
    b = {li[1], i[1]};
    case (mode)
      1:       return a & b;
      2:       return a ^ b;
      default: return a | b;
    endcase
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q3.size();
  endfunction

  function automatic logic [1:0] qfront(input int k);
    return (k == 0) ? q0[0] : q3[0];
  endfunction

  task automatic qpush(input int k, input logic [1:0] v);
    if (k == 0) q0.push_back(v); else q3.push_back(v);
  endtask

  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front()); else void'(q3.pop_front());
  endtask

  task automatic reset_model();
    q0.delete();
    q3.delete();
    for (int k = 0; k < 2; k++) begin
      ms1v[k] = 1'b0; ms1d[k] = 2'b00; mrdy[k] = 1'b0; erdy[k] = 1'b0; last_acc[k] = 1'b0;
    end
  endtask

  task automatic get_dut(input int k, output logic ov, output logic ir, output logic [1:0] o,
                         output logic [1:0] on, output logic lo, output logic [1:0] cnt);
    if (k == 0) begin
      ov = bus0.out_valid; ir = bus0.in_ready; o = bus0.O; on = bus0.O_n; lo = bus0.lifted_output; cnt = bus0.count;
    end else begin
      ov = bus3.out_valid; ir = bus3.in_ready; o = bus3.O; on = bus3.O_n; lo = bus3.lifted_output; cnt = bus3.count;
    end
  endtask

  task automatic check_model(input int k);
    logic ov, ir, lo;
    logic [1:0] o, on, cnt, f, fn;
    int sz, d;
    get_dut(k, ov, ir, o, on, lo, cnt);
    sz = qsize(k);
    d  = (k == 0) ? 2 : 3;
    erdy[k] = mrdy[k] && (!ms1v[k] || sz < d || (sz > 0 && stim_ready)) && !stim_flush;
    chk($sformatf("dut%0d out_valid", k), ov, (sz != 0));
    chk($sformatf("dut%0d count", k), cnt, 8'(sz));
    chk($sformatf("dut%0d in_ready", k), ir, erdy[k]);
    if (sz != 0) begin
      f  = qfront(k);
      fn = ~f;
      chk($sformatf("dut%0d O", k), o, f);
      chk($sformatf("dut%0d O_n", k), on, fn);
      chk($sformatf("dut%0d lifted_output", k), lo, f[0]);
    end
  endtask

  task automatic update_model(input int k);
    int sz, d;
    logic pop, room;
    last_acc[k] = 1'b0;
    if (!rst_n) return;
    d  = (k == 0) ? 2 : 3;
    sz = qsize(k);
    if (stim_flush) begin
      if (k == 0) q0.delete(); else q3.delete();
      ms1v[k] = 1'b0;
    end else begin
      pop  = (sz > 0) && stim_ready;
      room = (sz < d) || pop;
      if (pop) qpop(k);
      if (ms1v[k] && room) begin
        qpush(k, ms1d[k]);
        ms1v[k] = 1'b0;
      end
      if (stim_valid && erdy[k]) begin
        ms1d[k]     = ref_red((k == 0) ? 0 : 2, stim_i, stim_li);
        ms1v[k]     = 1'b1;
        last_acc[k] = 1'b1;
      end
    end
    mrdy[k] = 1'b1;
  endtask

  // Check both tracked instances, advance one clock, update the model.
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) check_model(k);
    @(posedge CLK);
    for (int k = 0; k < 2; k++) update_model(k);
    @(negedge CLK);
  endtask

  logic [1:0] bp_i  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] bp_li [4] = '{2'b01, 2'b00, 2'b11, 2'b00};

  initial begin
    int idx;
    int acc3;
    logic [3:0] jj;
    rst_n = 1'b0; stim_i = 2'b00; stim_li = 2'b00;
    stim_valid = 1'b0; stim_flush = 1'b0; stim_ready = 1'b0;
    reset_model();

    // Reset state
    @(negedge CLK);
    chk("reset out_valid", bus0.out_valid, 1'b0);
    chk("reset count", bus0.count, 2'd0);
    chk("reset O", bus0.O, 2'b00);
    chk("reset O_n", bus0.O_n, 2'b11);
    chk("reset lifted_output", bus0.lifted_output, 1'b0);
    chk("reset in_ready", bus0.in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Basic beat across all modes
    stim_i = 2'b01; stim_li = 2'b10; stim_valid = 1'b1; stim_ready = 1'b1;
    tick();
    stim_valid = 1'b0;
    tick();
    chk("mode_and O", bus1.O, 2'b00);
    chk("mode_and out_valid", bus1.out_valid, 1'b1);
    chk("mode_xor O", bus2.O, 2'b11);
    chk("mode_xor O_n", bus2.O_n, 2'b00);
    chk("mode_or O", bus0.O, 2'b11);
    tick();
    tick();

    // All-zero operands
    stim_i = 2'b00; stim_li = 2'b00; stim_valid = 1'b1;
    tick();
    stim_valid = 1'b0;
    tick();
    chk("zero O", bus0.O, 2'b00);
    chk("zero O_n", bus0.O_n, 2'b11);
    tick();
    tick();

    // Backpressure: four beats offered with the output stalled
    stim_ready = 1'b0; stim_valid = 1'b1; idx = 0;
    for (int t = 0; t < 5; t++) begin
      stim_i = bp_i[idx]; stim_li = bp_li[idx];
      tick();
      if (last_acc[0] && idx < 3) idx++;
    end
    #1;
    chk("backpressure count", bus0.count, 2'd2);
    chk("backpressure in_ready", bus0.in_ready, 1'b0);
    chk("backpressure head", bus0.O, ref_red(0, bp_i[0], bp_li[0]));
    stim_ready = 1'b1;
    for (int t = 0; t < 4 && !last_acc[0]; t++) tick();
    stim_valid = 1'b0;
    for (int t = 0; t < 6; t++) tick();

    // Full FIFO with simultaneous push and pop every cycle
    stim_ready = 1'b0; stim_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      stim_i = 2'(t); stim_li = 2'b01;
      tick();
    end
    stim_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      jj = 4'(j);
      stim_i = jj[1:0]; stim_li = ~jj[2:1];
      tick();
      chk("fullpp count", bus0.count, 2'd2);
      chk("fullpp out_valid", bus0.out_valid, 1'b1);
    end
    stim_valid = 1'b0;
    for (int t = 0; t < 5; t++) tick();

    // Flush with FIFO full and S1 occupied
    stim_ready = 1'b0; stim_valid = 1'b1; stim_i = 2'b11; stim_li = 2'b00;
    for (int t = 0; t < 3; t++) tick();
    stim_flush = 1'b1; stim_ready = 1'b1;
    tick();
    stim_flush = 1'b0; stim_valid = 1'b0;
    #1;
    chk("flush count", bus0.count, 2'd0);
    chk("flush out_valid", bus0.out_valid, 1'b0);
    chk("flush in_ready", bus0.in_ready, 1'b1);
    stim_i = 2'b10; stim_li = 2'b01; stim_valid = 1'b1;
    tick();
    stim_valid = 1'b0;
    tick();
    chk("post_flush O", bus0.O, 2'b11);
    tick();
    tick();

    // Asynchronous reset between edges while one result is buffered
    stim_ready = 1'b0; stim_valid = 1'b1; stim_i = 2'b01; stim_li = 2'b00;
    tick();
    stim_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset count", bus0.count, 2'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", bus0.out_valid, 1'b0);
    chk("midreset count", bus0.count, 2'd0);
    chk("midreset O", bus0.O, 2'b00);
    chk("midreset O_n", bus0.O_n, 2'b11);
    chk("midreset in_ready", bus0.in_ready, 1'b0);
    chk("midreset dut3 count", bus3.count, 2'd0);
    reset_model();
    tick();
    rst_n = 1'b1; stim_ready = 1'b1;
    for (int t = 0; t < 4; t++) tick();

    // Depth-3 pointer wrap: seven accepted beats, irregular drain
    acc3 = 0;
    stim_valid = 1'b1;
    for (int t = 0; t < 40 && acc3 < 7; t++) begin
      jj = 4'(acc3 * 5 + 3);
      stim_i = jj[1:0]; stim_li = jj[3:2];
      stim_ready = (t % 3) != 0;
      tick();
      if (last_acc[1]) acc3++;
    end
    chk("wrap beats accepted", 8'(acc3), 8'd7);
    stim_valid = 1'b0; stim_ready = 1'b1;
    for (int t = 0; t < 8; t++) tick();
    chk("wrap drained dut3", bus3.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
